// File: rtl/rob_commit_ctrl.sv
// ROB commit controller: 2-wide alloc, writeback done bitmap, in-order 2-wide commit, flush; COMMIT_EXC_EN adds exceptions.
// Commit/flush outputs register one cycle after the decision; alloc_ready is combinational (count <= ROB_NUM-2).
module rob_commit_ctrl #(
    parameter int ROB_NUM = 16,
    parameter int ROB_SEL = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               alloc_valid_1,
    input  logic               alloc_valid_2,
    output logic               alloc_ready,
    output logic [ROB_SEL-1:0] alloc_idx_1,
    output logic [ROB_SEL-1:0] alloc_idx_2,
    input  logic               wb_valid_1,
    input  logic               wb_valid_2,
    input  logic [ROB_SEL-1:0] wb_idx_1,
    input  logic [ROB_SEL-1:0] wb_idx_2,
`ifdef COMMIT_EXC_EN
    input  logic               wb_exc_1,
    input  logic               wb_exc_2,
    output logic [ROB_SEL-1:0] exc_idx,
`endif
    input  logic               violation_detected,
    output logic               commit_enable_1,
    output logic               commit_enable_2,
    output logic [ROB_SEL-1:0] commit_idx_1,
    output logic [ROB_SEL-1:0] commit_idx_2,
    output logic               flush_out,
    output logic [ROB_SEL:0]   rob_count
);

    localparam logic [ROB_SEL:0] READY_MAX = (ROB_SEL+1)'(ROB_NUM - 2);

    logic [ROB_SEL-1:0] head, tail, head_p1;
    logic [ROB_SEL:0]   count, n_alloc, n_commit;
    logic [ROB_NUM-1:0] valid, done;
`ifdef COMMIT_EXC_EN
    logic [ROB_NUM-1:0] exc;
`endif
    logic head_ok, pair_ok, c1, c2, exc_take, flush, do_alloc;

    assign head_p1     = head + ROB_SEL'(1);
    assign alloc_ready = (count <= READY_MAX);
    assign alloc_idx_1 = tail;
    assign alloc_idx_2 = tail + ROB_SEL'(1);
    assign rob_count   = count;

    // Commit is decided purely from registered state, so a writeback lands one cycle before it can commit.
    always_comb begin
        head_ok  = (count != '0) && done[head];
        pair_ok  = (count >= (ROB_SEL+1)'(2)) && done[head_p1];
`ifdef COMMIT_EXC_EN
        exc_take = head_ok && exc[head];
        c1       = head_ok && !exc[head];
        c2       = c1 && pair_ok && !exc[head_p1];
`else
        exc_take = 1'b0;
        c1       = head_ok;
        c2       = c1 && pair_ok;
`endif
        flush    = violation_detected || exc_take;
        do_alloc = alloc_valid_1 && alloc_ready;
        n_alloc  = '0;
        if (do_alloc)
            n_alloc = alloc_valid_2 ? (ROB_SEL+1)'(2) : (ROB_SEL+1)'(1);
        n_commit = (ROB_SEL+1)'(c1) + (ROB_SEL+1)'(c2);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head            <= '0;
            tail            <= '0;
            count           <= '0;
            valid           <= '0;
            done            <= '0;
            commit_enable_1 <= 1'b0;
            commit_enable_2 <= 1'b0;
            commit_idx_1    <= '0;
            commit_idx_2    <= '0;
            flush_out       <= 1'b0;
`ifdef COMMIT_EXC_EN
            exc             <= '0;
            exc_idx         <= '0;
`endif
        end else if (flush) begin
            head            <= '0;
            tail            <= '0;
            count           <= '0;
            valid           <= '0;
            done            <= '0;
            commit_enable_1 <= 1'b0;
            commit_enable_2 <= 1'b0;
            commit_idx_1    <= '0;
            commit_idx_2    <= '0;
            flush_out       <= 1'b1;
`ifdef COMMIT_EXC_EN
            exc             <= '0;
            if (exc_take)
                exc_idx <= head;
`endif
        end else begin
            flush_out       <= 1'b0;
            commit_enable_1 <= c1;
            commit_enable_2 <= c2;
            commit_idx_1    <= c1 ? head : '0;
            commit_idx_2    <= c2 ? head_p1 : '0;
            // Ordering matters: later assignments (commit clear, then allocation) override writebacks.
            if (wb_valid_1 && valid[wb_idx_1]) begin
                done[wb_idx_1] <= 1'b1;
`ifdef COMMIT_EXC_EN
                exc[wb_idx_1]  <= wb_exc_1;
`endif
            end
            if (wb_valid_2 && valid[wb_idx_2]) begin
                done[wb_idx_2] <= 1'b1;
`ifdef COMMIT_EXC_EN
                exc[wb_idx_2]  <= wb_exc_2;
`endif
            end
            if (c1) begin
                valid[head] <= 1'b0;
                done[head]  <= 1'b0;
            end
            if (c2) begin
                valid[head_p1] <= 1'b0;
                done[head_p1]  <= 1'b0;
            end
            if (do_alloc) begin
                valid[tail] <= 1'b1;
                done[tail]  <= 1'b0;
`ifdef COMMIT_EXC_EN
                exc[tail]   <= 1'b0;
`endif
                if (alloc_valid_2) begin
                    valid[alloc_idx_2] <= 1'b1;
                    done[alloc_idx_2]  <= 1'b0;
`ifdef COMMIT_EXC_EN
                    exc[alloc_idx_2]   <= 1'b0;
`endif
                end
            end
            head  <= head + ROB_SEL'(n_commit);
            tail  <= tail + ROB_SEL'(n_alloc);
            count <= count + n_alloc - n_commit;
        end
    end

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Directed bench for rob_commit_ctrl: expected commit indices are queued at stimulus time and popped as commits appear.
module tb_rob_commit_ctrl;
    localparam int ROB_NUM = 16;
    localparam int ROB_SEL = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic               alloc_valid_1, alloc_valid_2, alloc_ready;
    logic [ROB_SEL-1:0] alloc_idx_1, alloc_idx_2;
    logic               wb_valid_1, wb_valid_2;
    logic [ROB_SEL-1:0] wb_idx_1, wb_idx_2;
`ifdef COMMIT_EXC_EN
    logic               wb_exc_1, wb_exc_2;
    logic [ROB_SEL-1:0] exc_idx;
`endif
    logic               violation_detected;
    logic               commit_enable_1, commit_enable_2;
    logic [ROB_SEL-1:0] commit_idx_1, commit_idx_2;
    logic               flush_out;
    logic [ROB_SEL:0]   rob_count;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    rob_commit_ctrl #(.ROB_NUM(ROB_NUM), .ROB_SEL(ROB_SEL)) dut (
        .clk(clk), .reset(reset),
        .alloc_valid_1(alloc_valid_1), .alloc_valid_2(alloc_valid_2), .alloc_ready(alloc_ready),
        .alloc_idx_1(alloc_idx_1), .alloc_idx_2(alloc_idx_2),
        .wb_valid_1(wb_valid_1), .wb_valid_2(wb_valid_2), .wb_idx_1(wb_idx_1), .wb_idx_2(wb_idx_2),
`ifdef COMMIT_EXC_EN
        .wb_exc_1(wb_exc_1), .wb_exc_2(wb_exc_2), .exc_idx(exc_idx),
`endif
        .violation_detected(violation_detected),
        .commit_enable_1(commit_enable_1), .commit_enable_2(commit_enable_2),
        .commit_idx_1(commit_idx_1), .commit_idx_2(commit_idx_2),
        .flush_out(flush_out), .rob_count(rob_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        alloc_valid_1      = 1'b0;
        alloc_valid_2      = 1'b0;
        wb_valid_1         = 1'b0;
        wb_valid_2         = 1'b0;
        wb_idx_1           = '0;
        wb_idx_2           = '0;
        violation_detected = 1'b0;
`ifdef COMMIT_EXC_EN
        wb_exc_1           = 1'b0;
        wb_exc_2           = 1'b0;
`endif
    endtask

    // Advance one clock and score any commits the DUT reports against the queue.
    task automatic tick();
        int e;
        @(posedge clk);
        #1;
        check("en2_implies_en1", {31'd0, commit_enable_2 & ~commit_enable_1}, 0);
        if (commit_enable_1) begin
            check("commit1_expected", (exp_q.size() != 0) ? 1 : 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("commit_idx_1", {28'd0, commit_idx_1}, e);
            end
        end else begin
            check("idx1_zero_when_idle", {28'd0, commit_idx_1}, 0);
        end
        if (commit_enable_2) begin
            check("commit2_expected", (exp_q.size() != 0) ? 1 : 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("commit_idx_2", {28'd0, commit_idx_2}, e);
            end
        end else begin
            check("idx2_zero_when_idle", {28'd0, commit_idx_2}, 0);
        end
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() > 0; i++)
            tick();
        check("drain_queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;

        // Reset state and a first pair commit
        do_reset();
        check("rst_en1", {31'd0, commit_enable_1}, 0);
        check("rst_en2", {31'd0, commit_enable_2}, 0);
        check("rst_flush", {31'd0, flush_out}, 0);
        check("rst_count", {27'd0, rob_count}, 0);
        check("rst_ready", {31'd0, alloc_ready}, 1);
        alloc_valid_1 = 1'b1; alloc_valid_2 = 1'b1;
        check("t1_alloc_idx_1", {28'd0, alloc_idx_1}, 0);
        check("t1_alloc_idx_2", {28'd0, alloc_idx_2}, 1);
        exp_q.push_back(0); exp_q.push_back(1);
        tick();
        clear_inputs();
        check("t1_count2", {27'd0, rob_count}, 2);
        wb_valid_1 = 1'b1; wb_idx_1 = 4'd0;
        wb_valid_2 = 1'b1; wb_idx_2 = 4'd1;
        tick();
        clear_inputs();
        check("t1_no_early_commit", {31'd0, commit_enable_1}, 0);
        tick();
        check("t1_en1", {31'd0, commit_enable_1}, 1);
        check("t1_en2", {31'd0, commit_enable_2}, 1);
        tick();
        check("t1_count0", {27'd0, rob_count}, 0);
        check("t1_idle", {31'd0, commit_enable_1}, 0);

        // Out-of-order writebacks, in-order commit
        do_reset();
        alloc_valid_1 = 1'b1; alloc_valid_2 = 1'b1;
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
        tick();
        alloc_valid_2 = 1'b0;
        check("t2_alloc_idx_single", {28'd0, alloc_idx_1}, 2);
        tick();
        clear_inputs();
        wb_valid_1 = 1'b1; wb_idx_1 = 4'd2;
        tick();
        wb_idx_1 = 4'd1;
        tick();
        clear_inputs();
        tick();
        check("t2_blocked_head", {31'd0, commit_enable_1}, 0);
        check("t2_count3", {27'd0, rob_count}, 3);
        wb_valid_2 = 1'b1; wb_idx_2 = 4'd0;
        tick();
        clear_inputs();
        check("t2_not_yet", {31'd0, commit_enable_1}, 0);
        tick();
        check("t2_pair_en1", {31'd0, commit_enable_1}, 1);
        check("t2_pair_en2", {31'd0, commit_enable_2}, 1);
        tick();
        check("t2_single_en1", {31'd0, commit_enable_1}, 1);
        check("t2_single_en2", {31'd0, commit_enable_2}, 0);
        tick();
        check("t2_drained", {27'd0, rob_count}, 0);

        // Fill to ROB_NUM-1, backpressure, then alloc concurrent with commit
        do_reset();
        for (int i = 0; i < 7; i++) begin
            alloc_valid_1 = 1'b1; alloc_valid_2 = 1'b1;
            check("t3_ready_filling", {31'd0, alloc_ready}, 1);
            tick();
        end
        alloc_valid_2 = 1'b0;
        tick();
        check("t3_count15", {27'd0, rob_count}, 15);
        check("t3_not_ready", {31'd0, alloc_ready}, 0);
        alloc_valid_1 = 1'b1; alloc_valid_2 = 1'b1;
        tick();
        clear_inputs();
        check("t3_count_held", {27'd0, rob_count}, 15);
        check("t3_tail_held", {28'd0, alloc_idx_1}, 15);
        wb_valid_1 = 1'b1; wb_idx_1 = 4'd0;
        exp_q.push_back(0);
        tick();
        wb_idx_1 = 4'd1;
        exp_q.push_back(1);
        tick();
        clear_inputs();
        check("t3_commit0", {31'd0, commit_enable_1}, 1);
        check("t3_count14", {27'd0, rob_count}, 14);
        check("t3_ready_again", {31'd0, alloc_ready}, 1);
        alloc_valid_1 = 1'b1; alloc_valid_2 = 1'b1;
        check("t3_wrap_idx1", {28'd0, alloc_idx_1}, 15);
        check("t3_wrap_idx2", {28'd0, alloc_idx_2}, 0);
        tick();
        clear_inputs();
        check("t3_alloc_and_commit_count", {27'd0, rob_count}, 15);
        check("t3_commit1_en1", {31'd0, commit_enable_1}, 1);
        check("t3_commit1_en2", {31'd0, commit_enable_2}, 0);
        check("t3_full_again", {31'd0, alloc_ready}, 0);

        // Walk head and tail to 15, then commit a pair across the wrap
        do_reset();
        for (int k = 0; k < 15; k++) begin
            clear_inputs();
            alloc_valid_1 = 1'b1;
            exp_q.push_back(k);
            if (k > 0) begin
                wb_valid_1 = 1'b1;
                wb_idx_1   = ROB_SEL'(k - 1);
            end
            tick();
        end
        clear_inputs();
        wb_valid_1 = 1'b1; wb_idx_1 = 4'd14;
        tick();
        clear_inputs();
        drain(10);
        check("t4_empty", {27'd0, rob_count}, 0);
        alloc_valid_1 = 1'b1; alloc_valid_2 = 1'b1;
        check("t4_alloc_idx_1", {28'd0, alloc_idx_1}, 15);
        check("t4_alloc_idx_2", {28'd0, alloc_idx_2}, 0);
        exp_q.push_back(15); exp_q.push_back(0);
        tick();
        clear_inputs();
        wb_valid_1 = 1'b1; wb_idx_1 = 4'd15;
        wb_valid_2 = 1'b1; wb_idx_2 = 4'd0;
        tick();
        clear_inputs();
        tick();
        check("t4_wrap_en2", {31'd0, commit_enable_2}, 1);
        check("t4_wrap_idx1", {28'd0, commit_idx_1}, 15);
        check("t4_wrap_idx2", {28'd0, commit_idx_2}, 0);

        // Violation with same-cycle alloc and writeback
        do_reset();
        alloc_valid_1 = 1'b1; alloc_valid_2 = 1'b1;
        tick();
        tick();
        alloc_valid_2 = 1'b0;
        tick();
        clear_inputs();
        wb_valid_1 = 1'b1; wb_idx_1 = 4'd1;
        wb_valid_2 = 1'b1; wb_idx_2 = 4'd2;
        tick();
        clear_inputs();
        check("t5_count5", {27'd0, rob_count}, 5);
        violation_detected = 1'b1;
        alloc_valid_1 = 1'b1; alloc_valid_2 = 1'b1;
        wb_valid_1 = 1'b1; wb_idx_1 = 4'd0;
        check("t5_ready_preflush", {31'd0, alloc_ready}, 1);
        tick();
        clear_inputs();
        check("t5_flush", {31'd0, flush_out}, 1);
        check("t5_no_commit", {31'd0, commit_enable_1}, 0);
        check("t5_count0", {27'd0, rob_count}, 0);
        check("t5_tail0", {28'd0, alloc_idx_1}, 0);
        tick();
        check("t5_flush_one_cycle", {31'd0, flush_out}, 0);
        alloc_valid_1 = 1'b1; alloc_valid_2 = 1'b1;
        exp_q.push_back(0);
        tick();
        clear_inputs();
        wb_valid_1 = 1'b1; wb_idx_1 = 4'd0;
        tick();
        clear_inputs();
        tick();
        check("t5_post_en1", {31'd0, commit_enable_1}, 1);
        check("t5_stale_done_cleared", {31'd0, commit_enable_2}, 0);
        tick();
        check("t5_post_count", {27'd0, rob_count}, 1);

`ifdef COMMIT_EXC_EN
        // Exception on head+1: head commits alone, then flush with exc_idx
        do_reset();
        check("t6_exc_idx_rst", {28'd0, exc_idx}, 0);
        alloc_valid_1 = 1'b1; alloc_valid_2 = 1'b1;
        exp_q.push_back(0);
        tick();
        clear_inputs();
        wb_valid_1 = 1'b1; wb_idx_1 = 4'd0;
        wb_valid_2 = 1'b1; wb_idx_2 = 4'd1; wb_exc_2 = 1'b1;
        tick();
        clear_inputs();
        tick();
        check("t6_en1", {31'd0, commit_enable_1}, 1);
        check("t6_en2", {31'd0, commit_enable_2}, 0);
        check("t6_no_flush_yet", {31'd0, flush_out}, 0);
        tick();
        check("t6_flush", {31'd0, flush_out}, 1);
        check("t6_exc_idx", {28'd0, exc_idx}, 1);
        check("t6_count0", {27'd0, rob_count}, 0);
`endif

        check("final_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rob_commit_ctrl.md
Name: rob_commit_ctrl

Overview:
- Commit-side controller for the reorder buffer.
- Allocates up to two ROB indices per cycle to dispatch and records execution writebacks into a per-entry done bitmap.
- Drives in-order, up to 2-wide commit handshakes (commit_enable_1/2 plus index) toward the ROB and rename/free-list logic.
- Performs a global flush on memory-order violation.

Parameters:
- ROB_NUM, 16, number of ROB entries; must be a power of two, >= 4.
- ROB_SEL, 4, index width; equals log2(ROB_NUM).

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- alloc_valid_1  input  1  dispatch requests one entry (slot 1).
- alloc_valid_2  input  1  dispatch requests a second entry; honoured only together with alloc_valid_1.
- alloc_ready  output  1  combinational; 1 when count <= ROB_NUM-2.
- alloc_idx_1  output  ROB_SEL  index granted to slot 1; equals tail.
- alloc_idx_2  output  ROB_SEL  index granted to slot 2; equals (tail+1) mod ROB_NUM.
- wb_valid_1, wb_valid_2  input  1 each  execution writeback strobes.
- wb_idx_1, wb_idx_2  input  ROB_SEL each  completed entry indices.
- violation_detected  input  1  memory-order violation; flush request.
- commit_enable_1, commit_enable_2  output  1 each  registered commit strobes.
- commit_idx_1, commit_idx_2  output  ROB_SEL each  registered committed indices.
- flush_out  output  1  registered one-cycle flush pulse.
- rob_count  output  ROB_SEL+1  registered occupancy.

Behaviour:
- Reset (synchronous): head=0, tail=0, count=0; all valid/done bits 0.
  - Outputs: commit_enable_*=0, commit_idx_*=0, flush_out=0, rob_count=0, alloc_ready=1.
- Allocation:
  - Fires when alloc_valid_1 && alloc_ready.
  - n_alloc = 1 + (alloc_valid_2 ? 1 : 0).
  - alloc_valid_2 without alloc_valid_1 is ignored.
  - Allocated entries: valid=1, done=0. tail advances by n_alloc modulo ROB_NUM.
- Writeback:
  - done[wb_idx]=1 only if valid[wb_idx]=1; writeback to an invalid entry is ignored.
  - Both ports may write the same index in one cycle (idempotent).
  - Allocation to an index wins over a same-cycle writeback to that index.
- Commit decision is taken from registered state only; a writeback in cycle N is first visible to commit in cycle N+1.
  - c1 = count>=1 && done[head].
  - c2 = c1 && count>=2 && done[head+1 mod ROB_NUM].
  - Outputs register one cycle later: commit_enable_1=c1, commit_idx_1=head, commit_enable_2=c2, commit_idx_2=head+1. Each idx is driven 0 when its enable is 0.
  - commit_enable_2 is never 1 while commit_enable_1 is 0.
  - Committed entries: valid=0, done=0. head advances by c1+c2.
- Count update: count <= count + n_alloc - (c1+c2), all in the same cycle; width ROB_SEL+1, never exceeds ROB_NUM.
  - Simultaneous allocate and commit at full-minus-2 is legal.
- Wrap-around: head, tail and idx+1 all wrap modulo ROB_NUM. A pair allocated across the wrap gets indices ROB_NUM-1 and 0.
- Flush: violation_detected=1 in cycle N has priority over everything else.
  - head=tail=count=0; all valid/done cleared.
  - Allocations, writebacks and commits decided in cycle N are discarded.
  - In cycle N+1: commit_enable_*=0 and flush_out=1, for exactly one cycle.
  - Because alloc_ready is combinational from registered state, it stays at its pre-flush value during cycle N.
- Reset asserted mid-operation overrides flush and all other activity.

Optional Feature:
- Macro: COMMIT_EXC_EN.
- Defined:
  - Adds ports wb_exc_1, wb_exc_2 (input, 1 bit each) and exc_idx (output, ROB_SEL), plus a per-entry exc bit written along with done.
  - If head is done with exc=1: c1=c2=0. Next cycle flush_out=1 and exc_idx=head, and the full flush is performed as for a violation.
  - If only head+1 has exc=1: commit head alone (c2=0); the exception is taken in the following decision cycle.
  - exc_idx resets to 0.
- Undefined: those ports and the exc state are absent; flush_out is caused by violation_detected only.

Test Plan:
- Reset, alloc pair (idx 0,1), wb both in cycle 2 -> cycle 4 commit_enable_1=1/idx0 and commit_enable_2=1/idx1; rob_count=0 in cycle 5.
- Alloc 0,1,2; wb idx2 then idx1 -> no commit; wb idx0 -> next decision commits 0,1; idx2 commits alone one cycle later.
- ROB_NUM=16: 7 pair-allocs plus 1 single (count=15) -> alloc_ready=0; alloc_valid asserted -> no change; one commit -> alloc_ready=1.
- Drive head/tail to 15: alloc pair -> alloc_idx_1=15, alloc_idx_2=0; both done -> commit_idx_1=15, commit_idx_2=0.
- count=5 with done entries, violation_detected plus same-cycle alloc and wb -> next cycle flush_out=1, commit_enable_*=0, rob_count=0, alloc_idx_1=0.
- COMMIT_EXC_EN: idx0 done, idx1 done with exc -> commit idx0 only; next decision flush_out=1, exc_idx=1.
